jtbubl_irqctl: RTL and testbench

Parametrised interrupt and watchdog controller for the JTBUBL CPU boards. It generalises the per-CPU vblank interrupt flip-flops, the MCU stretched-IRQ counter and the LVBL-counting watchdog into one block. The block serves CH interrupt channels, each selectable between latched-until-acknowledge and fixed-length pulse mode. One watchdog generates a timed CPU reset. It sits between the video timing / MCU port outputs and the Z80 / 6801 `int_n` and `rst_n` inputs.

---
 rtl/jtbubl_irq_pkg.sv | 22 ++
 rtl/jtbubl_irq_chan.sv | 80 ++++++++
 rtl/jtbubl_irqctl.sv | 120 ++++++++++++
 tb/tb_jtbubl_irqctl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_irq_pkg.sv
// ============================================================================
// jtbubl_irq_pkg : shared encodings and counter-width helper for jtbubl_irqctl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package jtbubl_irq_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic MODE_LATCH = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtbubl_irq_chan.sv
// ============================================================================
// jtbubl_irq_chan : one interrupt channel (edge detect, pending, pulse timer, mask)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module jtbubl_irq_chan
  import jtbubl_irq_pkg::*;
#(
  parameter int STRETCH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic src,
  input  logic mode,
  input  logic mask,
  input  logic ack,
  input  logic flush,
  output logic irq_n,
  output logic pending
);

  localparam int               c_cw   = cnt_w(STRETCH);
  localparam logic [c_cw-1:0]  c_load = c_cw'(STRETCH - 1);

  logic            r_prev;
  logic            r_mode;
  logic            r_pend;
  logic            r_irq_n;
  logic [c_cw-1:0] r_cnt;

  logic            w_edge;
  logic            w_mode_chg;
  logic            w_pend;
  logic [c_cw-1:0] w_cnt;

  always_comb begin
    w_edge     = src & ~r_prev;
    w_mode_chg = (mode != r_mode) & r_pend;
    w_pend     = r_pend;
    w_cnt      = r_cnt;
    if (flush || w_mode_chg) begin
      w_pend = 1'b0;
      w_cnt  = '0;
    end else if (mode == MODE_LATCH) begin
      // A new edge wins over a same-tick ack so the event is not lost
      w_pend = w_edge | (r_pend & ~ack);
      w_cnt  = '0;
    end else if (w_edge) begin
      w_pend = 1'b1;
      w_cnt  = c_load;
    end else if (r_pend) begin
      if (r_cnt == '0) w_pend = 1'b0;
      else             w_cnt  = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_mode  <= MODE_LATCH;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_irq_n <= 1'b1;
    end else if (cen) begin
      r_prev  <= src;
      r_mode  <= mode;
      r_pend  <= w_pend;
      r_cnt   <= w_cnt;
      r_irq_n <= ~(w_pend & ~mask);
    end
  end

  assign irq_n   = r_irq_n;
  assign pending = r_pend;

endmodule

`default_nettype wire

// File: rtl/jtbubl_irqctl.sv
// ============================================================================
// jtbubl_irqctl : CH-channel interrupt controller with LVBL frame watchdog
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module jtbubl_irqctl
  import jtbubl_irq_pkg::*;
#(
  parameter int CH       = 3,
  parameter int STRETCH  = 16,
  parameter int WDOG_W   = 8,
  parameter int WDOG_LIM = 128,
  parameter int RST_LEN  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LVBL,
  input  logic [CH-1:0] irq_src,
  input  logic [CH-1:0] irq_mode,
  input  logic [CH-1:0] irq_mask,
  input  logic [CH-1:0] irq_ack,
  input  logic          wdog_en,
  input  logic          wdog_clr,
  output logic [CH-1:0] irq_n,
  output logic [CH-1:0] pending,
  output logic          cpu_rst_n
);

  localparam int                c_tw        = cnt_w(RST_LEN);
  localparam logic [c_tw-1:0]   c_tick_last = c_tw'(RST_LEN - 1);
  localparam logic [WDOG_W-1:0] c_lim       = WDOG_W'(WDOG_LIM);

  logic [0:0]        r_state;
  logic [0:0]        w_state;
  logic [c_tw-1:0]   r_tick;
  logic [c_tw-1:0]   w_tick;
  logic [WDOG_W-1:0] r_count;
  logic [WDOG_W-1:0] w_count;
  logic              r_lvbl;
  logic              r_cpu_rst_n;
  logic              w_lvbl_edge;
  logic              w_cpu_rst_n;
  logic              w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_tick      <= '0;
      r_count     <= '0;
      r_lvbl      <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else if (cen) begin
      r_state     <= w_state;
      r_tick      <= w_tick;
      r_count     <= w_count;
      r_lvbl      <= LVBL;
      r_cpu_rst_n <= w_cpu_rst_n;
    end
  end

  always_comb begin
    w_lvbl_edge = LVBL & ~r_lvbl;
    w_state     = r_state;
    w_tick      = r_tick;
    w_count     = r_count;
    case (r_state)
      ST_RUN: begin
        // A kick outranks a frame edge landing on the same tick
        if (wdog_clr) begin
          w_count = '0;
        end else if (w_lvbl_edge && wdog_en && (r_count != '1)) begin
          w_count = r_count + 1'b1;
          if (w_count == c_lim) begin
            w_state = ST_HOLD;
            w_tick  = '0;
            w_count = '0;
          end
        end
      end
      default: begin
        if (r_tick == c_tick_last) begin
          w_state = ST_RUN;
          w_tick  = '0;
          w_count = '0;
        end else begin
          w_tick = r_tick + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_cpu_rst_n = (w_state == ST_RUN);
    w_flush     = (r_state == ST_RUN) && (w_state == ST_HOLD);
  end

  assign cpu_rst_n = r_cpu_rst_n;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    jtbubl_irq_chan #(
      .STRETCH (STRETCH)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .src     (irq_src[gi]),
      .mode    (irq_mode[gi]),
      .mask    (irq_mask[gi]),
      .ack     (irq_ack[gi]),
      .flush   (w_flush),
      .irq_n   (irq_n[gi]),
      .pending (pending[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_jtbubl_irqctl.sv
// ============================================================================
// tb_jtbubl_irqctl : directed and randomized checks of jtbubl_irqctl vs a model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtbubl_irqctl;

  localparam int CH       = 8;
  localparam int STRETCH  = 16;
  localparam int WDOG_W   = 8;
  localparam int WDOG_LIM = 4;
  localparam int RST_LEN  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          LVBL;
  logic [CH-1:0] irq_src;
  logic [CH-1:0] irq_mode;
  logic [CH-1:0] irq_mask;
  logic [CH-1:0] irq_ack;
  logic          wdog_en;
  logic          wdog_clr;
  logic [CH-1:0] irq_n;
  logic [CH-1:0] pending;
  logic          cpu_rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  jtbubl_irqctl #(
    .CH       (CH),
    .STRETCH  (STRETCH),
    .WDOG_W   (WDOG_W),
    .WDOG_LIM (WDOG_LIM),
    .RST_LEN  (RST_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .LVBL      (LVBL),
    .irq_src   (irq_src),
    .irq_mode  (irq_mode),
    .irq_mask  (irq_mask),
    .irq_ack   (irq_ack),
    .wdog_en   (wdog_en),
    .wdog_clr  (wdog_clr),
    .irq_n     (irq_n),
    .pending   (pending),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  // Reference model: pulse channels track "ticks of request left",
  // the watchdog tracks frames seen and reset ticks still to serve.
  logic [CH-1:0] m_prev, m_pend, m_mode, m_irqn;
  int            m_rem [CH];
  logic          m_lvbl;
  int            m_frames, m_hold;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mode = '0; m_irqn = '1;
    m_lvbl = 1'b0; m_frames = 0; m_hold = RST_LEN;
    for (int i = 0; i < CH; i++) m_rem[i] = 0;
  endtask

  task automatic model_tick();
    bit fire;
    bit e;
    fire = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (wdog_clr) begin
      m_frames = 0;
    end else if (LVBL && !m_lvbl && wdog_en) begin
      m_frames++;
      if (m_frames >= WDOG_LIM) begin
        fire = 1'b1; m_frames = 0; m_hold = RST_LEN;
      end
    end
    m_lvbl = LVBL;
    for (int i = 0; i < CH; i++) begin
      e = irq_src[i] && !m_prev[i];
      if (fire || (irq_mode[i] != m_mode[i] && m_pend[i])) begin
        m_pend[i] = 1'b0; m_rem[i] = 0;
      end else if (irq_mode[i] == 1'b0) begin
        m_pend[i] = e || (m_pend[i] && !irq_ack[i]);
        m_rem[i]  = 0;
      end else begin
        if (e)               m_rem[i] = STRETCH;
        else if (m_rem[i] > 0) m_rem[i]--;
        m_pend[i] = (m_rem[i] > 0);
      end
      m_prev[i] = irq_src[i];
      m_mode[i] = irq_mode[i];
      m_irqn[i] = !(m_pend[i] && !irq_mask[i]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit c);
    cen = c;
    @(posedge clk);
    if (c) model_tick();
    #1;
    check("irq_n",     32'(irq_n),     32'(m_irqn));
    check("pending",   32'(pending),   32'(m_pend));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_hold == 0));
  endtask

  task automatic frame(input bit clr);
    LVBL = 1'b1; wdog_clr = clr; step(1'b1);
    LVBL = 1'b0; wdog_clr = 1'b0; step(1'b1);
  endtask

  task automatic wait_run(input string tag, output int ticks);
    ticks = 0;
    for (int t = 1; t <= 4 * RST_LEN; t++) begin
      step(1'b1);
      if (cpu_rst_n === 1'b1) begin ticks = t; break; end
    end
    check(tag, 32'(ticks), 32'(RST_LEN));
  endtask

  task automatic pulse_len(input int retrig_at, output int len);
    irq_ack[1] = 1'b1;
    irq_src[1] = 1'b1;
    step(1'b1);
    len = (irq_n[1] === 1'b0) ? 1 : 0;
    for (int t = 1; t < 200; t++) begin
      irq_src[1] = (retrig_at > 0 && t == retrig_at);
      step(1'b1);
      if (irq_n[1] === 1'b0) len++;
      else if (t > retrig_at) break;
    end
    irq_src[1] = 1'b0;
    irq_ack[1] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cen = 1'b0; LVBL = 1'b0;
    irq_src = '0; irq_mode = '0; irq_mask = '0; irq_ack = '0;
    wdog_en = 1'b0; wdog_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq_n",   32'(irq_n),     32'hFF);
    check("rst_pending", 32'(pending),   32'h0);
    check("rst_cpu_rst", 32'(cpu_rst_n), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    wait_run("powerup_rst_len", n);

    // Latched mode on channel 0
    irq_src[0] = 1'b1; step(1'b1);
    check("lat_set", 32'(irq_n[0]), 32'h0);
    irq_src[0] = 1'b0; repeat (3) step(1'b1);
    irq_ack[0] = 1'b1; step(1'b1);
    check("lat_ack", 32'(irq_n[0]), 32'h1);
    irq_ack[0] = 1'b0; step(1'b1);
    irq_src[0] = 1'b1; irq_ack[0] = 1'b1; step(1'b1);
    check("lat_edge_ack", 32'(irq_n[0]), 32'h0);
    irq_src[0] = 1'b0; irq_ack[0] = 1'b0; step(1'b1);
    irq_ack[0] = 1'b1; step(1'b1); irq_ack[0] = 1'b0;

    // Pulse mode on channel 1, ack held high throughout
    irq_mode[1] = 1'b1; repeat (2) step(1'b1);
    pulse_len(0, n);
    check("pulse_len", 32'(n), 32'(STRETCH));
    repeat (2) step(1'b1);
    pulse_len(8, n);
    check("pulse_retrig_len", 32'(n), 32'(STRETCH + 8));

    // Masked capture on channel 2
    irq_mask[2] = 1'b1;
    irq_src[2] = 1'b1; step(1'b1);
    irq_src[2] = 1'b0; step(1'b1);
    check("mask_pending", 32'(pending[2]), 32'h1);
    check("mask_irq_n",   32'(irq_n[2]),   32'h1);
    irq_mask[2] = 1'b0; step(1'b1);
    check("unmask_irq_n", 32'(irq_n[2]), 32'h0);
    irq_ack[2] = 1'b1; step(1'b1); irq_ack[2] = 1'b0;

    // Watchdog fire with a pending request in flight
    irq_src[0] = 1'b1; step(1'b1); irq_src[0] = 1'b0;
    wdog_en = 1'b1;
    repeat (WDOG_LIM - 1) frame(1'b0);
    LVBL = 1'b1; step(1'b1);
    check("wdog_fire", 32'(cpu_rst_n), 32'h0);
    check("wdog_flush", 32'(pending), 32'h0);
    LVBL = 1'b0;
    n = 1;
    for (int t = 0; t < 4 * RST_LEN && cpu_rst_n !== 1'b1; t++) begin
      step(1'b1);
      if (cpu_rst_n === 1'b0) n++;
    end
    check("wdog_low_len", 32'(n), 32'(RST_LEN));

    repeat (3 * WDOG_LIM) frame(1'b1);
    check("wdog_kicked", 32'(cpu_rst_n), 32'h1);

    repeat (WDOG_LIM - 1) frame(1'b0);
    frame(1'b1);
    check("wdog_clr_on_edge", 32'(cpu_rst_n), 32'h1);
    repeat (WDOG_LIM - 1) frame(1'b0);
    check("wdog_count_zeroed", 32'(cpu_rst_n), 32'h1);
    LVBL = 1'b1; step(1'b1); LVBL = 1'b0;
    check("wdog_refire", 32'(cpu_rst_n), 32'h0);
    wait_run("wdog_recover", n);
    wdog_en = 1'b0;

    // Asynchronous reset in the middle of a pulse
    irq_src[1] = 1'b1; step(1'b1); irq_src[1] = 1'b0;
    repeat (3) step(1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_irq_n",   32'(irq_n),     32'hFF);
    check("async_pending", 32'(pending),   32'h0);
    check("async_cpu_rst", 32'(cpu_rst_n), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_run("async_rst_len", n);

    // Randomized traffic on all channels
    irq_mode = CH'($urandom);
    wdog_en  = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      irq_src  = irq_src ^ CH'($urandom & $urandom);
      irq_ack  = CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0)   irq_mask = CH'($urandom);
      if ($urandom_range(0, 99) == 0)  irq_mode = irq_mode ^ CH'(1 << $urandom_range(0, CH - 1));
      if ($urandom_range(0, 5) == 0)   LVBL = ~LVBL;
      wdog_en  = ($urandom_range(0, 9) != 0);
      wdog_clr = ($urandom_range(0, 29) == 0);
      step($urandom_range(0, 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
